// File: rtl/ipif_fifo_stream_bridge.sv
// Bridges the IPIF write/read FIFO request/ack ports to a pair of valid/ready streams,
// with a prefetch buffer on the engine-bound side and a one-word holding register on the return side.
module ipif_fifo_stream_bridge #(
    parameter int DWIDTH  = 64,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 32
) (
    input  logic                      bus2ip_clk,
    input  logic                      bus2ip_reset_n,
    input  logic                      soft_clr,
    output logic                      ip2wfifo_rdreq,
    input  logic                      wfifo2ip_rdack,
    input  logic [DWIDTH-1:0]         wfifo2ip_data,
    input  logic                      wfifo2ip_empty,
    output logic                      ip2rfifo_wrreq,
    output logic [DWIDTH-1:0]         ip2rfifo_data,
    input  logic                      rfifo2ip_wrack,
    input  logic                      rfifo2ip_full,
    output logic                      m_valid,
    output logic [DWIDTH-1:0]         m_data,
    input  logic                      m_ready,
    input  logic                      s_valid,
    input  logic [DWIDTH-1:0]         s_data,
    output logic                      s_ready,
    output logic [CNT_W-1:0]          words_in,
    output logic [CNT_W-1:0]          words_out,
    output logic                      err_rd_to,
    output logic                      err_wr_to,
    output logic                      rd_state_dbg,
    output logic                      wr_state_dbg,
    output logic [$clog2(DEPTH):0]    buf_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);

    typedef enum logic {RD_IDLE = 1'b0, RD_REQ = 1'b1} rd_state_t;
    typedef enum logic {WR_IDLE = 1'b0, WR_REQ = 1'b1} wr_state_t;

    rd_state_t         rd_state;
    wr_state_t         wr_state;
    logic [TW-1:0]     rd_wait;
    logic [TW-1:0]     wr_wait;
    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic [DWIDTH-1:0] hold;
    logic              push;
    logic              pop;

    // Stream handshake: a word moves on a cycle where valid and ready are both 1 at the
    // rising edge; valid never depends on ready, and the source holds data while waiting.
    assign push           = (rd_state == RD_REQ) && wfifo2ip_rdack;
    assign pop            = m_valid && m_ready;
    assign m_valid        = (count != '0);
    assign m_data         = m_valid ? mem[rd_ptr] : '0;
    assign ip2wfifo_rdreq = (rd_state == RD_REQ);
    assign s_ready        = (wr_state == WR_IDLE);
    assign ip2rfifo_wrreq = (wr_state == WR_REQ) && !rfifo2ip_full;
    assign ip2rfifo_data  = hold;
    assign rd_state_dbg   = rd_state;
    assign wr_state_dbg   = wr_state;
    assign buf_count      = count;

    // Requests are only issued with room guaranteed, so an ack can always be written.
    always_ff @(posedge bus2ip_clk or negedge bus2ip_reset_n) begin
        if (!bus2ip_reset_n) begin
            rd_state  <= RD_IDLE;
            rd_wait   <= '0;
            words_in  <= '0;
            err_rd_to <= 1'b0;
        end else if (soft_clr) begin
            rd_state  <= RD_IDLE;
            rd_wait   <= '0;
            words_in  <= '0;
            err_rd_to <= 1'b0;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (!wfifo2ip_empty && (count < FULL_CNT)) begin
                        rd_state <= RD_REQ;
                        rd_wait  <= '0;
                    end
                end
                RD_REQ: begin
                    if (wfifo2ip_rdack) begin
                        words_in <= words_in + CNT_W'(1);
                        rd_state <= RD_IDLE;
                    end else if (rd_wait == WAIT_LAST) begin
                        err_rd_to <= 1'b1;
                        rd_state  <= RD_IDLE;
                    end else begin
                        rd_wait <= rd_wait + TW'(1);
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

    always_ff @(posedge bus2ip_clk) begin
        if (push && !soft_clr) begin
            mem[wr_ptr] <= wfifo2ip_data;
        end
    end

    always_ff @(posedge bus2ip_clk or negedge bus2ip_reset_n) begin
        if (!bus2ip_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (soft_clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + (AW + 1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW + 1)'(1);
            end
        end
    end

    // The wait counter only advances while the read FIFO can accept, so back-pressure never times out.
    always_ff @(posedge bus2ip_clk or negedge bus2ip_reset_n) begin
        if (!bus2ip_reset_n) begin
            wr_state  <= WR_IDLE;
            wr_wait   <= '0;
            hold      <= '0;
            words_out <= '0;
            err_wr_to <= 1'b0;
        end else if (soft_clr) begin
            wr_state  <= WR_IDLE;
            wr_wait   <= '0;
            hold      <= '0;
            words_out <= '0;
            err_wr_to <= 1'b0;
        end else begin
            case (wr_state)
                WR_IDLE: begin
                    if (s_valid) begin
                        hold     <= s_data;
                        wr_state <= WR_REQ;
                        wr_wait  <= '0;
                    end
                end
                WR_REQ: begin
                    if (ip2rfifo_wrreq && rfifo2ip_wrack) begin
                        words_out <= words_out + CNT_W'(1);
                        wr_state  <= WR_IDLE;
                    end else if (!rfifo2ip_full) begin
                        if (wr_wait == WAIT_LAST) begin
                            err_wr_to <= 1'b1;
                            wr_state  <= WR_IDLE;
                        end else begin
                            wr_wait <= wr_wait + TW'(1);
                        end
                    end
                end
                default: wr_state <= WR_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ipif_fifo_stream_bridge.sv
// Directed bench for ipif_fifo_stream_bridge: FIFO responders, stream drivers and
// queue-based monitors for both directions.
module tb_ipif_fifo_stream_bridge;
    localparam int DW      = 64;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 64;
    localparam int CW      = 32;
    localparam int BW      = $clog2(DEPTH) + 1;

    logic          bus2ip_clk = 1'b0;
    logic          bus2ip_reset_n = 1'b0;
    logic          soft_clr = 1'b0;
    logic          ip2wfifo_rdreq;
    logic          wfifo2ip_rdack = 1'b0;
    logic [DW-1:0] wfifo2ip_data = '0;
    logic          wfifo2ip_empty = 1'b1;
    logic          ip2rfifo_wrreq;
    logic [DW-1:0] ip2rfifo_data;
    logic          rfifo2ip_wrack = 1'b0;
    logic          rfifo2ip_full = 1'b0;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready = 1'b0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_ready;
    logic [CW-1:0] words_in;
    logic [CW-1:0] words_out;
    logic          err_rd_to;
    logic          err_wr_to;
    logic          rd_state_dbg;
    logic          wr_state_dbg;
    logic [BW-1:0] buf_count;

    ipif_fifo_stream_bridge #(
        .DWIDTH(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CW)
    ) dut (
        .bus2ip_clk(bus2ip_clk), .bus2ip_reset_n(bus2ip_reset_n), .soft_clr(soft_clr),
        .ip2wfifo_rdreq(ip2wfifo_rdreq), .wfifo2ip_rdack(wfifo2ip_rdack),
        .wfifo2ip_data(wfifo2ip_data), .wfifo2ip_empty(wfifo2ip_empty),
        .ip2rfifo_wrreq(ip2rfifo_wrreq), .ip2rfifo_data(ip2rfifo_data),
        .rfifo2ip_wrack(rfifo2ip_wrack), .rfifo2ip_full(rfifo2ip_full),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .words_in(words_in), .words_out(words_out),
        .err_rd_to(err_rd_to), .err_wr_to(err_wr_to),
        .rd_state_dbg(rd_state_dbg), .wr_state_dbg(wr_state_dbg), .buf_count(buf_count)
    );

    // Clock and watchdog
    always #5 bus2ip_clk = ~bus2ip_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] src_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_w_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Write-FIFO responder: acks a pending rdreq after ack_lat waiting cycles.
    logic ack_en = 1'b1;
    int   ack_lat = 3;
    int   lat_cnt = 0;
    int   ack_count = 0;

    initial begin
        forever begin
            @(posedge bus2ip_clk); #1;
            wfifo2ip_rdack = 1'b0;
            if (ack_en && ip2wfifo_rdreq && src_q.size() > 0) begin
                if (lat_cnt >= ack_lat) begin
                    wfifo2ip_rdack = 1'b1;
                    wfifo2ip_data  = src_q.pop_front();
                    lat_cnt = 0;
                    ack_count++;
                end else begin
                    lat_cnt++;
                end
            end else begin
                lat_cnt = 0;
            end
            wfifo2ip_empty = (src_q.size() == 0);
        end
    end

    // Read-FIFO responder: optional full toggling every 20 cycles, ack after wack_lat wrreq cycles.
    logic wack_en = 1'b1;
    int   wack_lat = 1;
    int   wlat_cnt = 0;
    logic full_tog_en = 1'b0;
    int   tog_cnt = 0;

    initial begin
        forever begin
            @(posedge bus2ip_clk); #1;
            if (full_tog_en) begin
                if (tog_cnt == 19) begin
                    rfifo2ip_full = ~rfifo2ip_full;
                    tog_cnt = 0;
                end else begin
                    tog_cnt++;
                end
            end
            #1;
            rfifo2ip_wrack = 1'b0;
            if (wack_en && ip2rfifo_wrreq) begin
                if (wlat_cnt >= wack_lat) begin
                    rfifo2ip_wrack = 1'b1;
                    wlat_cnt = 0;
                end else begin
                    wlat_cnt++;
                end
            end
        end
    end

    // Scoreboard monitor: pops expected words as the DUT presents them.
    logic          prev_ok = 1'b0;
    logic [BW-1:0] prev_cnt = '0;
    int            prev_delta = 0;
    int            gated = 0;

    initial begin
        forever begin
            @(negedge bus2ip_clk);
            if (bus2ip_reset_n) begin
                if (prev_ok) begin
                    check("buf_count_step", 64'(buf_count), 64'(int'(prev_cnt) + prev_delta));
                end
                if (m_valid && m_ready && !soft_clr) begin
                    if (exp_q.size() == 0) check("m_unexpected_word", m_data, 64'hFFFF_FFFF_FFFF_FFFF);
                    else check("m_data", m_data, exp_q.pop_front());
                end
                if (wr_state_dbg) begin
                    if (rfifo2ip_full) begin
                        gated++;
                        check("wrreq_while_full", 64'(ip2rfifo_wrreq), 64'd0);
                    end
                    if (exp_w_q.size() == 0) check("rfifo_unexpected_word", ip2rfifo_data, 64'hFFFF_FFFF_FFFF_FFFF);
                    else check("rfifo_data_stable", ip2rfifo_data, exp_w_q[0]);
                    if (ip2rfifo_wrreq && rfifo2ip_wrack && exp_w_q.size() > 0) void'(exp_w_q.pop_front());
                end
                check("buf_count_le_depth", 64'(buf_count <= BW'(DEPTH)), 64'd1);
            end
            prev_ok    = bus2ip_reset_n && !soft_clr;
            prev_cnt   = buf_count;
            prev_delta = int'(ip2wfifo_rdreq && wfifo2ip_rdack) - int'(m_valid && m_ready);
        end
    end

    // Driver tasks
    task automatic push_rd_word(input logic [DW-1:0] w);
        src_q.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic set_m_ready(input logic v);
        @(posedge bus2ip_clk); #1;
        m_ready = v;
    endtask

    task automatic send_word(input logic [DW-1:0] w);
        int n = 0;
        @(posedge bus2ip_clk); #1;
        while (!s_ready && n < 500) begin
            @(posedge bus2ip_clk); #1;
            n++;
        end
        check("send_word_ready", 64'(s_ready), 64'd1);
        s_valid = 1'b1;
        s_data  = w;
        @(posedge bus2ip_clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_rd_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge bus2ip_clk);
            n++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_wr_drain(input string name, input int budget);
        int n = 0;
        while (exp_w_q.size() != 0 && n < budget) begin
            @(negedge bus2ip_clk);
            n++;
        end
        check(name, 64'(exp_w_q.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rdreq"}, 64'(ip2wfifo_rdreq), 64'd0);
        check({tag, "_wrreq"}, 64'(ip2rfifo_wrreq), 64'd0);
        check({tag, "_wrdata"}, ip2rfifo_data, 64'd0);
        check({tag, "_m_valid"}, 64'(m_valid), 64'd0);
        check({tag, "_m_data"}, m_data, 64'd0);
        check({tag, "_s_ready"}, 64'(s_ready), 64'd1);
        check({tag, "_words_in"}, 64'(words_in), 64'd0);
        check({tag, "_words_out"}, 64'(words_out), 64'd0);
        check({tag, "_err_rd"}, 64'(err_rd_to), 64'd0);
        check({tag, "_err_wr"}, 64'(err_wr_to), 64'd0);
    endtask

    logic [15:0] pat = 16'b1011_0010_1101_1001;

    initial begin
        int n;
        int k;
        int base;

        // Reset state
        repeat (3) @(negedge bus2ip_clk);
        check_reset_outputs("reset");
        @(posedge bus2ip_clk); #1;
        bus2ip_reset_n = 1'b1;

        // Write side with full toggling: 0xB01DFACE must go out exactly once
        wack_lat = 30;
        tog_cnt = 0;
        full_tog_en = 1'b1;
        exp_w_q.push_back(64'hB01DFACE);
        send_word(64'hB01DFACE);
        wait_wr_drain("wr_toggle_drain", 400);
        full_tog_en = 1'b0;
        rfifo2ip_full = 1'b0;
        repeat (2) @(negedge bus2ip_clk);
        check("words_out_after_toggle", 64'(words_out), 64'd1);
        check("full_gated_seen", 64'(gated > 0), 64'd1);
        check("err_wr_after_toggle", 64'(err_wr_to), 64'd0);

        // Back-to-back writes
        wack_lat = 1;
        wlat_cnt = 0;
        exp_w_q.push_back(64'h11);
        exp_w_q.push_back(64'h22);
        exp_w_q.push_back(64'h33);
        send_word(64'h11);
        send_word(64'h22);
        send_word(64'h33);
        wait_wr_drain("wr_burst_drain", 200);
        repeat (2) @(negedge bus2ip_clk);
        check("words_out_after_burst", 64'(words_out), 64'd4);

        // 20 words through the prefetch buffer with 3-cycle ack latency
        set_m_ready(1'b1);
        ack_lat = 3;
        for (int i = 1; i <= 20; i++) push_rd_word(64'(i));
        wait_rd_drain("rd_seq_drain", 1000);
        repeat (2) @(negedge bus2ip_clk);
        check("words_in_after_seq", 64'(words_in), 64'd20);

        // Spurious rdack while idle must be ignored
        @(posedge bus2ip_clk); #2;
        wfifo2ip_rdack = 1'b1;
        wfifo2ip_data  = 64'hDEAD;
        @(posedge bus2ip_clk); #2;
        wfifo2ip_rdack = 1'b0;
        repeat (3) @(negedge bus2ip_clk);
        check("spurious_words_in", 64'(words_in), 64'd20);
        check("spurious_m_valid", 64'(m_valid), 64'd0);

        // Back-pressure: exactly DEPTH acks, then one more per single pop
        set_m_ready(1'b0);
        ack_lat = 1;
        base = ack_count;
        for (int i = 0; i < 12; i++) push_rd_word(64'h100 + 64'(i));
        repeat (150) @(negedge bus2ip_clk);
        check("bp_ack_count", 64'(ack_count - base), 64'd8);
        check("bp_buf_full", 64'(buf_count), 64'd8);
        check("bp_rdreq_idle", 64'(ip2wfifo_rdreq), 64'd0);
        check("bp_head", m_data, 64'h100);
        set_m_ready(1'b1);
        set_m_ready(1'b0);
        repeat (30) @(negedge bus2ip_clk);
        check("bp_one_more_ack", 64'(ack_count - base), 64'd9);
        check("bp_refilled", 64'(buf_count), 64'd8);
        set_m_ready(1'b1);
        wait_rd_drain("bp_drain", 500);
        repeat (2) @(negedge bus2ip_clk);
        check("words_in_after_bp", 64'(words_in), 64'd32);

        // Full buffer with concurrent acks and irregular pops across pointer wraps
        set_m_ready(1'b0);
        ack_lat = 0;
        for (int i = 0; i < 8; i++) push_rd_word(64'h200 + 64'(i));
        repeat (40) @(negedge bus2ip_clk);
        check("wrap_prefill", 64'(buf_count), 64'd8);
        for (int i = 8; i < 24; i++) push_rd_word(64'h200 + 64'(i));
        for (int i = 0; i < 64; i++) set_m_ready(pat[i % 16]);
        set_m_ready(1'b1);
        wait_rd_drain("wrap_drain", 500);
        repeat (2) @(negedge bus2ip_clk);
        check("words_in_after_wrap", 64'(words_in), 64'd56);

        // Write-side timeout: word discarded after TIMEOUT request cycles
        wack_en = 1'b0;
        exp_w_q.push_back(64'hBAD0);
        send_word(64'hBAD0);
        n = 0;
        k = 0;
        while (!s_ready && k < 300) begin
            @(negedge bus2ip_clk);
            if (ip2rfifo_wrreq) n++;
            k++;
        end
        check("wr_to_req_cycles", 64'(n), 64'(TIMEOUT));
        check("err_wr_to_set", 64'(err_wr_to), 64'd1);
        check("words_out_after_wr_to", 64'(words_out), 64'd4);
        if (exp_w_q.size() > 0) void'(exp_w_q.pop_front());
        wack_en = 1'b1;
        wlat_cnt = 0;

        // Read-side timeout, sticky flag, soft clear
        ack_en = 1'b0;
        push_rd_word(64'h4242);
        k = 0;
        while (!ip2wfifo_rdreq && k < 20) begin
            @(negedge bus2ip_clk);
            k++;
        end
        n = 0;
        while (ip2wfifo_rdreq && n < 200) begin
            n++;
            @(negedge bus2ip_clk);
        end
        check("rd_to_req_cycles", 64'(n), 64'(TIMEOUT));
        check("rd_to_rdreq_dropped", 64'(ip2wfifo_rdreq), 64'd0);
        check("err_rd_to_set", 64'(err_rd_to), 64'd1);
        check("rd_to_buf_unchanged", 64'(buf_count), 64'd0);
        repeat (10) @(negedge bus2ip_clk);
        check("err_rd_to_sticky", 64'(err_rd_to), 64'd1);
        @(posedge bus2ip_clk); #1;
        soft_clr = 1'b1;
        @(posedge bus2ip_clk); #1;
        soft_clr = 1'b0;
        @(negedge bus2ip_clk);
        check("clr_err_rd", 64'(err_rd_to), 64'd0);
        check("clr_err_wr", 64'(err_wr_to), 64'd0);
        check("clr_words_in", 64'(words_in), 64'd0);
        check("clr_words_out", 64'(words_out), 64'd0);
        ack_en = 1'b1;
        ack_lat = 2;
        wait_rd_drain("after_clr_drain", 200);
        repeat (2) @(negedge bus2ip_clk);
        check("words_in_after_clr", 64'(words_in), 64'd1);

        // Reset mid-request on both sides
        ack_en = 1'b0;
        wack_en = 1'b0;
        push_rd_word(64'h4444);
        exp_w_q.push_back(64'h5555);
        send_word(64'h5555);
        repeat (3) @(negedge bus2ip_clk);
        check("pre_reset_rdreq", 64'(ip2wfifo_rdreq), 64'd1);
        check("pre_reset_wrreq", 64'(ip2rfifo_wrreq), 64'd1);
        @(posedge bus2ip_clk); #3;
        bus2ip_reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_w_q.delete();
        wlat_cnt = 0;
        @(posedge bus2ip_clk); #1;
        bus2ip_reset_n = 1'b1;
        ack_en = 1'b1;
        wack_en = 1'b1;
        wack_lat = 0;
        wait_rd_drain("post_reset_rd_drain", 200);
        exp_w_q.push_back(64'h6666);
        send_word(64'h6666);
        wait_wr_drain("post_reset_wr_drain", 200);
        repeat (2) @(negedge bus2ip_clk);
        check("post_reset_words_in", 64'(words_in), 64'd1);
        check("post_reset_words_out", 64'(words_out), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
